// File: rtl/mmcm_phase_servo_pkg.sv
// Shared types, widths and parameter defaults for the MMCM fine-phase servo.
package mmcm_servo_pkg;

    localparam int POS_W   = 16;
    localparam int STATE_W = 2;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_ACC_W       = 16;
    localparam int DEF_THRESH      = 64;
    localparam int DEF_TIMEOUT_CYC = 1023;
    localparam int DEF_SETTLE_CYC  = 32;
    localparam int DEF_LOCK_CYC    = 4096;

    localparam logic signed [POS_W-1:0] POS_MAX = 16'sh7FFF;
    localparam logic signed [POS_W-1:0] POS_MIN = 16'sh8000;
    localparam logic signed [POS_W-1:0] POS_ONE = 16'sd1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_STEP      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_SETTLE    = 2'd3
    } servo_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mmcm_phase_servo_if.sv
// MMCM dynamic phase-shift port for one channel.
// psen is a one-cycle request qualified by psincdec; the MMCM answers with a
// one-cycle psdone some cycles later, and only one request is ever outstanding.
interface mmcm_phase_servo_if;
    logic psen;
    logic psincdec;
    logic psdone;

    modport master (output psen, output psincdec, input psdone);
    modport slave  (input psen, input psincdec, output psdone);
endinterface

// File: rtl/mmcm_phase_servo_ch.sv
// One servo channel: integrates early/late strobes and issues single MMCM
// fine-phase steps, tracking the net step count, lock and timeout status.
module mmcm_servo_ch
    import mmcm_servo_pkg::*;
#(
    parameter int ACC_W       = DEF_ACC_W,
    parameter int THRESH      = DEF_THRESH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int LOCK_CYC    = DEF_LOCK_CYC
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    early_i,
    input  logic                    late_i,
    mmcm_phase_servo_if.master      ps,
    output logic signed [POS_W-1:0] phase_pos_o,
    output logic                    locked_o,
    output logic                    timeout_err_o,
    output servo_state_e            state_o
);

    localparam int CNT_W = $clog2(max_int(TIMEOUT_CYC, SETTLE_CYC) + 1);
    localparam int LCK_W = $clog2(LOCK_CYC + 1);

    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] TH_P    = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] TH_N    = -TH_P;

    servo_state_e             state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     incdec_q, incdec_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LCK_W-1:0]         lock_q, lock_d;
    logic signed [POS_W-1:0]  pos_q, pos_d;
    logic                     terr_q, terr_d;
    logic                     step_go;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            incdec_q <= 1'b0;
            cnt_q    <= '0;
            lock_q   <= '0;
            pos_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            incdec_q <= incdec_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            pos_q    <= pos_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        incdec_d = incdec_q;
        cnt_d    = cnt_q;
        lock_d   = '0;
        pos_d    = pos_q;
        terr_d   = terr_q;
        step_go  = 1'b0;

        // Opposing strobes in the same cycle cancel out.
        if (late_i && !early_i) begin
            if (acc_q != ACC_MAX) acc_d = acc_q + ACC_ONE;
        end else if (early_i && !late_i) begin
            if (acc_q != ACC_MIN) acc_d = acc_q - ACC_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && (acc_q >= TH_P || acc_q <= TH_N)) begin
                    step_go  = 1'b1;
                    incdec_d = (acc_q >= TH_P);
                    state_d  = ST_STEP;
                end
            end
            ST_STEP: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (ps.psdone) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                    if (incdec_q) begin
                        if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
                    end else begin
                        if (pos_q != POS_MIN) pos_d = pos_q - POS_ONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                acc_d = '0;
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable_i) acc_d = '0;

        // Lock counts quiet idle cycles and saturates at the lock threshold.
        if (state_q == ST_IDLE && enable_i && !step_go) begin
            lock_d = (lock_q == LCK_W'(LOCK_CYC)) ? lock_q : lock_q + LCK_W'(1);
        end
    end

    assign ps.psen       = (state_q == ST_STEP);
    assign ps.psincdec   = (state_q == ST_STEP) && incdec_q;
    assign phase_pos_o   = pos_q;
    assign locked_o      = (lock_q == LCK_W'(LOCK_CYC)) && enable_i;
    assign timeout_err_o = terr_q;
    assign state_o       = state_q;

endmodule

// File: rtl/mmcm_phase_servo.sv
// Multi-channel MMCM phase servo: reset synchroniser plus N_CH independent
// servo channels, each talking to its MMCM through a phase-shift interface.
module mmcm_phase_servo
    import mmcm_servo_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int THRESH      = DEF_THRESH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int LOCK_CYC    = DEF_LOCK_CYC
) (
    input  logic                      clk_in,
    input  logic                      reset_in_n,
    input  logic                      enable,
    input  logic [N_CH-1:0]           early,
    input  logic [N_CH-1:0]           late,
    input  logic [N_CH-1:0]           psdone,
    output logic [N_CH-1:0]           psen,
    output logic [N_CH-1:0]           psincdec,
    output logic [N_CH*POS_W-1:0]     phase_pos,
    output logic [N_CH-1:0]           locked,
    output logic [N_CH-1:0]           timeout_err,
    output logic [N_CH*STATE_W-1:0]   fsm_state
);

    // Assert asynchronously, release two clocks after reset_in_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_sync;

    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_sync = rst_sync_q[1];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mmcm_phase_servo_if ps_if ();
        servo_state_e       ch_state;

        assign ps_if.psdone = psdone[g];
        assign psen[g]      = ps_if.psen;
        assign psincdec[g]  = ps_if.psincdec;

        mmcm_servo_ch #(
            .ACC_W       (ACC_W),
            .THRESH      (THRESH),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .SETTLE_CYC  (SETTLE_CYC),
            .LOCK_CYC    (LOCK_CYC)
        ) u_ch (
            .clk_i         (clk_in),
            .rst_n_i       (rst_n_sync),
            .enable_i      (enable),
            .early_i       (early[g]),
            .late_i        (late[g]),
            .ps            (ps_if),
            .phase_pos_o   (phase_pos[g*POS_W +: POS_W]),
            .locked_o      (locked[g]),
            .timeout_err_o (timeout_err[g]),
            .state_o       (ch_state)
        );

        assign fsm_state[g*STATE_W +: STATE_W] = ch_state;
    end

endmodule

// File: tb/tb_mmcm_phase_servo.sv
// Directed bench for mmcm_phase_servo with a cycle-level reference model of
// the servo rules checked every clock, plus hand-computed literal checks.
module tb_mmcm_phase_servo;

    localparam int N_CH        = 2;
    localparam int ACC_W       = 16;
    localparam int THRESH      = 64;
    localparam int TIMEOUT_CYC = 1023;
    localparam int SETTLE_CYC  = 32;
    localparam int LOCK_CYC    = 4096;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic reset_in_n;
    always #5 clk_in = ~clk_in;

    logic              enable;
    logic [N_CH-1:0]   early, late, psdone_w;
    logic [N_CH-1:0]   psen, psincdec, locked, timeout_err;
    logic [N_CH*16-1:0] phase_pos;
    logic [N_CH*2-1:0] fsm_state;

    mmcm_phase_servo_if ps0 ();
    mmcm_phase_servo_if ps1 ();

    assign ps0.psen     = psen[0];
    assign ps0.psincdec = psincdec[0];
    assign ps1.psen     = psen[1];
    assign ps1.psincdec = psincdec[1];
    assign psdone_w     = {ps1.psdone, ps0.psdone};

    mmcm_phase_servo #(
        .N_CH(N_CH), .ACC_W(ACC_W), .THRESH(THRESH), .TIMEOUT_CYC(TIMEOUT_CYC),
        .SETTLE_CYC(SETTLE_CYC), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .clk_in(clk_in), .reset_in_n(reset_in_n), .enable(enable),
        .early(early), .late(late), .psdone(psdone_w),
        .psen(psen), .psincdec(psincdec), .phase_pos(phase_pos),
        .locked(locked), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 step request, 2 waiting for psdone, 3 settling
    int m_acc[N_CH], m_pos[N_CH], m_phase[N_CH], m_cnt[N_CH], m_quiet[N_CH];
    bit m_dir[N_CH], m_terr[N_CH];
    int rel_edges;

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_acc[ch] = 0; m_pos[ch] = 0; m_phase[ch] = 0; m_cnt[ch] = 0;
            m_quiet[ch] = 0; m_dir[ch] = 1'b0; m_terr[ch] = 1'b0;
        end
        rel_edges = 0;
    endtask

    task automatic model_step(input int ch, input bit en, input bit e, input bit l, input bit d);
        int a, na, amax, old_phase;
        bit go;
        a = m_acc[ch];
        na = a;
        amax = (1 << (ACC_W - 1)) - 1;
        go = 1'b0;
        old_phase = m_phase[ch];
        if (l && !e) na = (a < amax) ? a + 1 : a;
        else if (e && !l) na = (a > -amax) ? a - 1 : a;
        case (old_phase)
            0: if (en && (a >= THRESH || a <= -THRESH)) begin
                go = 1'b1;
                m_dir[ch] = (a >= THRESH);
                m_phase[ch] = 1;
            end
            1: begin m_phase[ch] = 2; m_cnt[ch] = 0; end
            2: if (d) begin
                na = 0;
                if (m_dir[ch]) m_pos[ch] = (m_pos[ch] < 32767) ? m_pos[ch] + 1 : m_pos[ch];
                else           m_pos[ch] = (m_pos[ch] > -32768) ? m_pos[ch] - 1 : m_pos[ch];
                m_phase[ch] = 3;
                m_cnt[ch] = SETTLE_CYC;
            end else begin
                m_cnt[ch]++;
                if (m_cnt[ch] == TIMEOUT_CYC) begin
                    m_terr[ch] = 1'b1;
                    na = 0;
                    m_phase[ch] = 0;
                end
            end
            default: begin
                na = 0;
                m_cnt[ch]--;
                if (m_cnt[ch] == 0) m_phase[ch] = 0;
            end
        endcase
        if (!en) na = 0;
        m_quiet[ch] = (old_phase == 0 && en && !go) ? m_quiet[ch] + 1 : 0;
        m_acc[ch] = na;
    endtask

    task automatic compare_ch(input int ch);
        logic [1:0]  pe_act, pe_exp;
        logic [15:0] pos_exp;
        pe_act  = (ch == 0) ? {ps0.psen, ps0.psincdec} : {ps1.psen, ps1.psincdec};
        pe_exp  = {m_phase[ch] == 1, (m_phase[ch] == 1) && m_dir[ch]};
        pos_exp = 16'(m_pos[ch]);
        check($sformatf("ch%0d psen_psincdec", ch), 32'(pe_act), 32'(pe_exp));
        check($sformatf("ch%0d phase_pos", ch), 32'(phase_pos[ch*16 +: 16]), 32'(pos_exp));
        check($sformatf("ch%0d locked", ch), 32'(locked[ch]),
              32'((m_quiet[ch] >= LOCK_CYC) && enable));
        check($sformatf("ch%0d timeout_err", ch), 32'(timeout_err[ch]), 32'(m_terr[ch]));
        check($sformatf("ch%0d fsm_state", ch), 32'(fsm_state[ch*2 +: 2]), 32'(m_phase[ch]));
    endtask

    // ---------------- scoreboard: model vs DUT every cycle ----------------
    always @(posedge clk_in) begin
        bit              en_s;
        logic [N_CH-1:0] e_s, l_s, d_s;
        en_s = enable; e_s = early; l_s = late; d_s = psdone_w;
        if (!reset_in_n) begin
            model_reset();
        end else begin
            if (rel_edges >= 2)
                for (int ch = 0; ch < N_CH; ch++) model_step(ch, en_s, e_s[ch], l_s[ch], d_s[ch]);
            if (rel_edges < 2) rel_edges++;
        end
        #1;
        if (chk_en)
            for (int ch = 0; ch < N_CH; ch++) compare_ch(ch);
    end

    // ---------------- driver ----------------
    task automatic step(input bit en, input logic [1:0] e, input logic [1:0] l, input logic [1:0] d);
        @(negedge clk_in);
        enable = en; early = e; late = l;
        ps0.psdone = d[0]; ps1.psdone = d[1];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, pc;
        reset_in_n = 1'b0; enable = 1'b0; early = '0; late = '0;
        ps0.psdone = 1'b0; ps1.psdone = 1'b0;
        model_reset();
        @(negedge clk_in);
        chk_en = 1'b1;
        repeat (3) step(0, 2'b00, 2'b00, 2'b00);
        check("reset psen", 32'(psen), 0);
        check("reset phase_pos", 32'(phase_pos), 0);
        check("reset timeout_err", 32'(timeout_err), 0);
        check("reset locked", 32'(locked), 0);
        check("reset fsm_state", 32'(fsm_state), 0);
        @(negedge clk_in);
        reset_in_n = 1'b1;
        repeat (4) step(1, 2'b00, 2'b00, 2'b00);

        // ch0: 63 late strobes stay below threshold, the 64th triggers a step
        repeat (63) step(1, 2'b00, 2'b01, 2'b00);
        pc = 0;
        repeat (6) begin step(1, 2'b00, 2'b00, 2'b00); if (psen != 0) pc++; end
        check("no step below thresh", 32'(pc), 0);
        step(1, 2'b00, 2'b01, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        check("psen one cycle after strobe", 32'(psen[0]), 0);
        step(1, 2'b00, 2'b00, 2'b00);
        check("psen two cycles after strobe", 32'(psen[0]), 1);
        check("psincdec inc", 32'(psincdec[0]), 1);
        repeat (9) step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b01);
        step(1, 2'b00, 2'b00, 2'b00);
        check("ch0 phase_pos +1", 32'(phase_pos[15:0]), 32'h0001);
        repeat (40) step(1, 2'b00, 2'b00, 2'b00);

        // ch1: 64 early strobes, ch0 must stay put
        repeat (64) step(1, 2'b10, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        check("ch1 dec psen", 32'(psen), 32'b10);
        check("ch1 dec psincdec", 32'(psincdec), 0);
        repeat (5) step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b10);
        step(1, 2'b00, 2'b00, 2'b00);
        check("ch1 phase_pos -1", 32'(phase_pos[31:16]), 32'hFFFF);
        check("ch0 phase_pos kept", 32'(phase_pos[15:0]), 32'h0001);
        repeat (40) step(1, 2'b00, 2'b00, 2'b00);

        // ch0 step with psdone withheld: STEP cycle plus 1023 WAIT cycles
        repeat (64) step(1, 2'b00, 2'b01, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        check("timeout step psen", 32'(psen), 32'b01);
        k = 0;
        while (timeout_err[0] !== 1'b1 && k < 1100) begin
            step(1, 2'b00, 2'b00, 2'b00);
            k++;
        end
        check("timeout latency", 32'(k), 1024);
        check("timeout_err set", 32'(timeout_err), 32'b01);
        check("timeout back to idle", 32'(fsm_state[1:0]), 0);
        check("timeout phase_pos kept", 32'(phase_pos[15:0]), 32'h0001);

        // both strobes together: no steps, lock after LOCK_CYC quiet cycles
        step(0, 2'b00, 2'b00, 2'b00);
        n = 0; pc = 0;
        do begin
            step(1, 2'b11, 2'b11, 2'b00);
            n++;
            if (psen != 0) pc++;
        end while (locked !== 2'b11 && n < 5000);
        check("lock cycles", 32'(n - 1), LOCK_CYC);
        check("no psen with cancelling strobes", 32'(pc), 0);
        check("timeout_err sticky", 32'(timeout_err), 32'b01);
        step(0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b00);
        check("locked cleared by enable", 32'(locked), 0);

        // reset in the middle of WAIT_DONE
        repeat (64) step(1, 2'b00, 2'b01, 2'b00);
        repeat (2) step(1, 2'b00, 2'b00, 2'b00);
        check("pre-reset psen", 32'(psen), 32'b01);
        repeat (5) step(1, 2'b00, 2'b00, 2'b00);
        @(negedge clk_in);
        reset_in_n = 1'b0;
        #1;
        check("async reset psen", 32'(psen), 0);
        check("async reset psincdec", 32'(psincdec), 0);
        check("async reset phase_pos", 32'(phase_pos), 0);
        check("async reset timeout_err", 32'(timeout_err), 0);
        check("async reset locked", 32'(locked), 0);
        check("async reset fsm_state", 32'(fsm_state), 0);
        repeat (2) step(1, 2'b00, 2'b00, 2'b00);
        @(negedge clk_in);
        reset_in_n = 1'b1;
        repeat (4) step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b01);
        repeat (2) step(1, 2'b00, 2'b00, 2'b00);
        check("late psdone ignored pos", 32'(phase_pos[15:0]), 0);
        check("late psdone ignored state", 32'(fsm_state[1:0]), 0);

        // enable drops one cycle after psen: step completes, no new steps
        repeat (64) step(1, 2'b00, 2'b01, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        check("enable-drop psen", 32'(psen[0]), 1);
        repeat (6) step(0, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 2'b01);
        step(0, 2'b00, 2'b00, 2'b00);
        check("enable-drop step completes", 32'(phase_pos[15:0]), 32'h0001);
        repeat (40) step(0, 2'b00, 2'b00, 2'b00);
        pc = 0;
        repeat (200) begin step(0, 2'b00, 2'b01, 2'b00); if (psen != 0) pc++; end
        check("no psen while disabled", 32'(pc), 0);
        check("disabled phase_pos kept", 32'(phase_pos[15:0]), 32'h0001);

        repeat (2) step(0, 2'b00, 2'b00, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
